// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save resolver: FSM encoding and
// parameter-derived helpers (chunk count, chunk-index width, legality).
package csa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of CHUNK-bit slices in a WIDTH-bit operand
    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Width of the chunk index; at least one bit even for a single chunk
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // WIDTH must split evenly into chunks and leave room for the shifted carry
    function automatic bit params_ok(input int width, input int chunk);
        return (chunk > 0) && (width >= 2) && (width % chunk == 0);
    endfunction

endpackage

// File: rtl/csa_chunk_adder.sv
// Combinational CHUNK-bit ripple adder built from full-adder cells that use
// the same sum (xor) / carry (majority) equations as the 3:2 compressor cell.
module csa_chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end

    assign cout = c[CHUNK];

endmodule

// File: rtl/csa_resolver.sv
// Resolves a carry-save (sum, carry) pair into plain binary, CHUNK bits per
// cycle, using a single small ripple adder and a carry register between chunks.
module csa_resolver
    import csa_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH+1:0] out_result
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IW     = idx_width(NCHUNK);
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    if (!params_ok(WIDTH, CHUNK)) begin : g_bad_params
        $error("csa_resolver: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    state_t           state;
    logic [WIDTH-1:0] opa;      // sum vector
    logic [WIDTH-1:0] opb;      // carry vector pre-shifted to its true weight
    logic             top;      // carry MSB that shifts out past WIDTH
    logic [IW-1:0]    idx;
    logic             cy;

    logic [CHUNK-1:0] ch_sum;
    logic             ch_cout;

    csa_chunk_adder #(.CHUNK(CHUNK)) u_add (
        .a    (opa[idx*CHUNK +: CHUNK]),
        .b    (opb[idx*CHUNK +: CHUNK]),
        .cin  (cy),
        .sum  (ch_sum),
        .cout (ch_cout)
    );

    // Control FSM with registered handshake outputs and chunk-serial result write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_result <= '0;
            opa        <= '0;
            opb        <= '0;
            top        <= 1'b0;
            idx        <= '0;
            cy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opa      <= in_sum;
                        opb      <= {in_carry[WIDTH-2:0], 1'b0};
                        top      <= in_carry[WIDTH-1];
                        idx      <= '0;
                        cy       <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    out_result[idx*CHUNK +: CHUNK] <= ch_sum;
                    cy  <= ch_cout;
                    idx <= idx + 1'b1;
                    if (idx == LAST) begin
                        // top (weight 2^WIDTH) plus final chunk carry fills the 2 MSBs
                        out_result[WIDTH+1:WIDTH] <= {1'b0, top} + {1'b0, ch_cout};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csa_resolver.sv
// Directed bench for csa_resolver: latency, chunk carry ripple, max value,
// backpressure, asynchronous reset mid-operation and back-to-back throughput.
module tb_csa_resolver;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_sum;
    logic [WIDTH-1:0]  in_carry;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH+1:0]  out_result;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    csa_resolver #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .in_carry   (in_carry),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept one pair, verify RUN latency, leave the block sitting in DONE
    task automatic run_op(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c,
                          input logic [WIDTH+1:0] exp, input string tag);
        chk({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
        in_sum   = s;
        in_carry = c;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sum   = 16'hDEAD;
        in_carry = 16'hBEEF;
        chk({tag, " in_ready run"}, 32'(in_ready), 32'd0);
        repeat (NCHUNK - 1) @(posedge clk);
        #1;
        chk({tag, " out_valid early"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, " result"}, 32'(out_result), 32'(exp));
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " out_valid cleared"}, 32'(out_valid), 32'd0);
        chk({tag, " in_ready back"}, 32'(in_ready), 32'd1);
    endtask

    logic [WIDTH-1:0] b2b_s [3];
    logic [WIDTH-1:0] b2b_c [3];
    logic [WIDTH+1:0] b2b_e [3];
    int               acc_cyc [3];

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sum    = '0;
        in_carry  = '0;
        out_ready = 1'b0;

        #2;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_result", 32'(out_result), 32'd0);
        #11 rst = 1'b0;
        @(posedge clk); #1;

        // 5+3+6 through a 3:2 cell -> sum 0, carry 7 -> 14
        run_op(16'h0000, 16'h0007, 18'h0000E, "roundtrip");
        release_out("roundtrip");

        // carry must ripple through two chunk boundaries
        run_op(16'h00FF, 16'h0001, 18'h00101, "ripple");
        release_out("ripple");

        run_op(16'hFFFF, 16'hFFFF, 18'h2FFFD, "max");
        chk("max top bits", 32'(out_result[WIDTH+1:WIDTH]), 32'd2);
        release_out("max");

        // Backpressure: DONE must hold while other inputs are offered
        run_op(16'h1111, 16'h2222, 18'h05555, "bp");
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            in_sum   = 16'h0F0F;
            in_carry = 16'h7777;
            @(posedge clk); #1;
            chk("bp out_valid hold", 32'(out_valid), 32'd1);
            chk("bp result stable", 32'(out_result), 32'h05555);
            chk("bp in_ready low", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        release_out("bp");

        // Asynchronous reset during the second RUN cycle drops the operation
        in_sum   = 16'hAAAA;
        in_carry = 16'h5555;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_result", 32'(out_result), 32'd0);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        chk("post-rst out_valid", 32'(out_valid), 32'd0);
        run_op(16'h1234, 16'h0001, 18'h01236, "post-rst");
        release_out("post-rst");

        // Back-to-back with in_valid and out_ready held high
        b2b_s[0] = 16'hFFFF; b2b_c[0] = 16'hFFFF; b2b_e[0] = 18'h2FFFD;
        b2b_s[1] = 16'h0000; b2b_c[1] = 16'h0000; b2b_e[1] = 18'h00000;
        b2b_s[2] = 16'h00FF; b2b_c[2] = 16'h0001; b2b_e[2] = 18'h00101;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            int k;
            k = 0;
            in_sum   = b2b_s[i];
            in_carry = b2b_c[i];
            while (!in_ready && k < 20) begin
                @(posedge clk); #1;
                k++;
            end
            chk("b2b accept timeout", 32'(in_ready), 32'd1);
            acc_cyc[i] = cyc + 1;
            @(posedge clk); #1;
            k = 0;
            while (!out_valid && k < 20) begin
                @(posedge clk); #1;
                k++;
            end
            chk("b2b out_valid timeout", 32'(out_valid), 32'd1);
            chk("b2b result", 32'(out_result), 32'(b2b_e[i]));
            if (i > 0)
                chk("b2b spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(NCHUNK + 2));
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("b2b final idle", 32'(in_ready), 32'd1);
        chk("b2b final out_valid", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/csa_resolver.md
Name: csa_resolver

Overview:
- Converts a redundant carry-save pair (sum vector, carry vector) from the 3:2 compressor arrays back into a plain binary value.
- Resolution is chunk-serial: CHUNK bits per cycle through a small ripple adder, instead of one full-width carry-propagate adder.
- Sits after the squaring and accumulation CSA trees in the neuron datapath.
- Valid/ready handshake on both sides; one operation in flight at a time.

Parameters:
- WIDTH, 16, width of the in_sum and in_carry vectors; must be a multiple of CHUNK.
- CHUNK, 4, bits resolved per cycle; NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_sum/in_carry are valid.
- in_ready  output  1  block can accept an operand pair.
- in_sum  input  WIDTH  CSA sum vector (weight 2^i per bit).
- in_carry  input  WIDTH  CSA carry vector, unshifted (bit i has weight 2^(i+1)).
- out_valid  output  1  out_result is valid.
- out_ready  input  1  downstream accepts the result.
- out_result  output  WIDTH+2  in_sum + 2*in_carry, zero-extended.

Behaviour:
- Reset, asynchronous, in any state:
  - state=IDLE, in_ready=1, out_valid=0, out_result=0.
  - Chunk index, chunk carry and operand registers all 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: A<=in_sum, B<={in_carry[WIDTH-2:0],1'b0}, top<=in_carry[WIDTH-1], idx<=0, cy<=0; go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle adds A/B chunk idx (bits idx*CHUNK+CHUNK-1 down to idx*CHUNK) plus cy.
  - Writes the CHUNK-bit sum into out_result at the same bit positions; cy<=chunk carry-out; idx<=idx+1.
  - On the cycle idx==NCHUNK-1: out_result[WIDTH+1:WIDTH] <= top + chunk carry-out (2-bit add); go to DONE.
- DONE:
  - out_valid=1; out_result held stable.
  - On out_ready: out_valid<=0, go to IDLE.
  - in_ready stays 0 in DONE, so there is no same-cycle re-accept.
- Latency: handshake accepted at edge t, out_valid high after edge t+NCHUNK. Default: 4 cycles.
- Throughput: at most one operation per NCHUNK+2 cycles.
- Arithmetic: unsigned. Max result 3*(2^WIDTH-1) fits WIDTH+2 bits; overflow cannot occur.
- Chunk carry chains between chunks only through cy; cy is cleared on every accept.
- out_result keeps the last completed value in IDLE and RUN. Bits not yet rewritten hold previous data, which is only meaningful when out_valid=1.
- Input handshake: in_valid while in_ready=0 is ignored. Inputs are sampled only on the accept edge; later changes to in_sum/in_carry have no effect.
- out_ready while out_valid=0 is ignored.
- Reset mid-RUN or in DONE: the operation is dropped and nothing is emitted.

Decomposition:
- Shared package (csa_pkg):
  - State encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - NCHUNK derivation and CHUNK-index width (clog2 of NCHUNK).
  - Elaboration-time check that WIDTH%CHUNK==0 and WIDTH>=2.
- Sub-module csa_chunk_adder:
  - Combinational CHUNK-bit ripple adder: a, b, cin -> sum, cout.
  - Built as a chain of full-adder cells using the same sum/majority equations as the existing 3:2 cell.
- The top level holds only the FSM and registers.

Test Plan:
- CSA round-trip: a=5, b=3, c=6 fed through 3:2 cells give in_sum=0x0000, in_carry=0x0007 -> out_result=0x0000E (14) exactly 4 cycles after accept.
- Carry ripple across chunks: in_sum=0x00FF, in_carry=0x0001 -> out_result=0x00101.
- Maximum value: in_sum=0xFFFF, in_carry=0xFFFF -> out_result=0x2FFFD; top bits = 2'b10.
- Backpressure: hold out_ready=0 for 5 cycles in DONE.
  - out_valid stays 1 and out_result stays stable; in_ready stays 0.
  - in_valid pulses with other data are ignored.
  - After out_ready=1: in_ready=1 on the next cycle.
- Reset mid-operation:
  - Assert rst asynchronously (between edges) at the second RUN cycle: in_ready=1, out_valid=0, out_result=0 immediately.
  - The next accept of in_sum=0x1234, in_carry=0x0001 -> 0x01236.
- Back-to-back: keep in_valid high with a new pair and out_ready high.
  - Accepts are spaced exactly NCHUNK+2=6 cycles apart.
  - Every result is correct, with no carry leaking between operations: a 0xFFFF+0xFFFF pair followed by 0x0000+0x0000 gives 0x00000.
